// File: rtl/detect_event_logger.sv
// rtl/detect_event_logger.sv - timestamped detection logger with FWFT FIFO, hit counter, overflow and irq
module detect_event_logger #(
    parameter int TS_W       = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16,
    parameter int IRQ_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       detected,
    input  logic                       clear,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           hit_count,
    output logic                       overflow,
    output logic                       irq
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [CNT_W-1:0] hits;
    logic            ovf;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    // a pop on a full FIFO frees the slot the same-cycle push lands in
    assign pop   = !empty && rd_ready && !clear;
    assign push  = detected && !clear && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            hits   <= '0;
            ovf    <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                hits   <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    level <= level + LW'(1);
                else if (pop && !push)
                    level <= level - LW'(1);
                if (detected && (hits != '1))
                    hits <= hits + CNT_W'(1);
                if (detected && full && !pop)
                    ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ts;
    end

    assign rd_valid   = !empty;
    assign rd_data    = empty ? '0 : mem[rd_ptr];
    assign fifo_level = level;
    assign hit_count  = hits;
    assign overflow   = ovf;
    assign irq        = (level >= LW'(IRQ_THRESH)) || ovf;
endmodule
